// File: rtl/ecc_pkg.sv
// ecc_pkg: op codes, P1 M-point constants and point type shared by the ECC point register file
// No ports; imported by ecc_q_stager and ecc_point_regfile.
package ecc_pkg;
  localparam int PT_W = 256;
  localparam logic [2:0] OP_SET_Q = 3'd0;
  localparam logic [2:0] OP_SET_T = 3'd1;
  localparam logic [2:0] OP_SET_N = 3'd2;
  localparam logic [2:0] OP_SET_M = 3'd3;
  localparam logic [2:0] OP_CLR   = 3'd4;
  localparam logic [2:0] OP_CSWAP = 3'd5;
  localparam logic [2:0] OP_COPY  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam logic [PT_W-1:0] P1_MXP = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
  localparam logic [PT_W-1:0] P1_MXN = 256'h0000000000000000000000000000000000000000000000000000000000000011;
  localparam logic [PT_W-1:0] P1_MYP = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
  localparam logic [PT_W-1:0] P1_MYN = 256'h0000000000000000000000000000000000000000000000000000000000000022;
  typedef struct packed {
    logic [PT_W-1:0] xp, xn, yp, yn;
  } ecc_pt_t;
endpackage

// File: rtl/ecc_q_stager.sv
// ecc_q_stager: BUS_W word stream to {Qy,Qx} staging buffer with beat counter and q_valid
// Ports: clk, rst (async, high); wr = accepted beat; data = beat word; q_valid, qx, qy = staged point.
module ecc_q_stager #(
  parameter int WIDTH = 256,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [BUS_W-1:0] data,
  output logic             q_valid,
  output logic [WIDTH-1:0] qx,
  output logic [WIDTH-1:0] qy
);
  localparam int BEATS = 2 * WIDTH / BUS_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  logic [BEATS-1:0][BUS_W-1:0] stg;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stg <= '0;
      cnt <= '0;
      q_valid <= 1'b0;
    end else if (wr) begin
      stg[cnt] <= data;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      q_valid <= cnt == LAST ? 1'b1 : cnt == '0 ? 1'b0 : q_valid;
    end
  // word 0 is the LSW of Qx, word BEATS/2 the LSW of Qy
  assign {qy, qx} = stg;
endmodule

// File: rtl/ecc_point_regfile.sv
// ecc_point_regfile: NSLOT redundant-form affine point slots with load/clear/copy/cswap ops
// Ports: clk, rst (async, high); ld_* host Q stream + q_valid; op_* request/commit handshake;
// t_x/t_y base point; fb_* ecp3 feedback; rd_slot selects rd_xp/xn/yp/yn (combinational).
module ecc_point_regfile
  import ecc_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int NSLOT = 4,
  parameter int BUS_W = 32,
  localparam int SW = $clog2(NSLOT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_vld,
  output logic             ld_rdy,
  input  logic [BUS_W-1:0] ld_data,
  output logic             q_valid,
  input  logic             op_vld,
  output logic             op_rdy,
  input  logic [2:0]       op_code,
  input  logic [SW-1:0]    op_dst,
  input  logic [SW-1:0]    op_src,
  input  logic             op_cond,
  input  logic [WIDTH-1:0] t_x,
  input  logic [WIDTH-1:0] t_y,
  input  logic [WIDTH-1:0] fb_xp,
  input  logic [WIDTH-1:0] fb_xn,
  input  logic [WIDTH-1:0] fb_yp,
  input  logic [WIDTH-1:0] fb_yn,
  input  logic [SW-1:0]    rd_slot,
  output logic [WIDTH-1:0] rd_xp,
  output logic [WIDTH-1:0] rd_xn,
  output logic [WIDTH-1:0] rd_yp,
  output logic [WIDTH-1:0] rd_yn,
  output logic             op_done,
  output logic             op_err
);
  typedef enum logic {IDLE, EXEC} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] xp, xn, yp, yn;
  } pt_t;
  localparam logic [WIDTH-1:0] Z = '0;
  state_t state, nxt;
  pt_t slot [NSLOT];
  pt_t opnd, wv, rv;
  logic [2:0] code;
  logic [SW-1:0] dst, src;
  logic cond, err, bad;
  logic [WIDTH-1:0] qx, qy;
  ecc_q_stager #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_stg (
    .clk(clk), .rst(rst), .wr(ld_vld & ld_rdy), .data(ld_data),
    .q_valid(q_valid), .qx(qx), .qy(qy)
  );
  // rejection is decided at accept, so a final beat landing on the same edge is not seen
  assign bad = op_code == OP_RSVD || 32'(op_dst) >= NSLOT || 32'(op_src) >= NSLOT ||
               (op_code == OP_SET_Q && !q_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE && op_vld ? EXEC : IDLE;
    op_rdy = state == IDLE;
    op_done = state == EXEC && !err;
    op_err = state == EXEC && err;
    ld_rdy = !(state == EXEC && code == OP_SET_Q && !err);
  end
  // T and N operands are captured at accept; staging is read at commit while ld_rdy freezes it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      code <= '0;
      dst <= '0;
      src <= '0;
      cond <= 1'b0;
      err <= 1'b0;
      opnd <= '0;
    end else if (state == IDLE && op_vld) begin
      code <= op_code;
      dst <= op_dst;
      src <= op_src;
      cond <= op_cond;
      err <= bad;
      opnd <= op_code == OP_SET_T ? {t_x, Z, t_y, Z} : {fb_xp, fb_xn, fb_yp, fb_yn};
    end
  assign wv = code == OP_SET_Q ? {qx, Z, qy, Z} :
              code == OP_SET_M ? {WIDTH'(P1_MXP), WIDTH'(P1_MXN), WIDTH'(P1_MYP), WIDTH'(P1_MYN)} :
              code == OP_CLR ? '0 : opnd;
  // CSWAP always rewrites both slots so activity does not depend on cond
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
    end else if (state == EXEC && !err) begin
      if (code == OP_CSWAP) begin
        slot[dst] <= cond ? slot[src] : slot[dst];
        slot[src] <= cond ? slot[dst] : slot[src];
      end else slot[dst] <= code == OP_COPY ? slot[src] : wv;
    end
  assign rv = 32'(rd_slot) < NSLOT ? slot[rd_slot] : '0;
  assign {rd_xp, rd_xn, rd_yp, rd_yn} = rv;
endmodule

// File: tb/tb_ecc_point_regfile.sv
// tb_ecc_point_regfile: scoreboard bench with a behavioural slot/staging model
module tb_ecc_point_regfile;
  import ecc_pkg::*;
  localparam int W = 256, NS = 5, BW = 32, SW = 3, BEATS = 2 * W / BW;
  logic clk = 0, rst = 1;
  logic ld_vld = 0, ld_rdy, q_valid, op_vld = 0, op_rdy, op_cond = 0, op_done, op_err;
  logic [BW-1:0] ld_data = '0;
  logic [2:0] op_code = '0;
  logic [SW-1:0] op_dst = '0, op_src = '0, rd_slot = '0;
  logic [W-1:0] t_x = '0, t_y = '0, fb_xp = '0, fb_xn = '0, fb_yp = '0, fb_yn = '0;
  logic [W-1:0] rd_xp, rd_xn, rd_yp, rd_yn;
  always #10 clk = ~clk;

  ecc_point_regfile #(.WIDTH(W), .NSLOT(NS), .BUS_W(BW)) dut (
    .clk(clk), .rst(rst), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_data(ld_data),
    .q_valid(q_valid), .op_vld(op_vld), .op_rdy(op_rdy), .op_code(op_code),
    .op_dst(op_dst), .op_src(op_src), .op_cond(op_cond), .t_x(t_x), .t_y(t_y),
    .fb_xp(fb_xp), .fb_xn(fb_xn), .fb_yp(fb_yp), .fb_yn(fb_yn), .rd_slot(rd_slot),
    .rd_xp(rd_xp), .rd_xn(rd_xn), .rd_yp(rd_yp), .rd_yn(rd_yn),
    .op_done(op_done), .op_err(op_err)
  );

  int total = 0, bad = 0, dones = 0;
  logic [W-1:0] mxp [NS], mxn [NS], myp [NS], myn [NS];
  logic [BW-1:0] words [BEATS];
  int beat = 0;
  bit mqv = 0, busy = 0, pend_q = 0;
  logic [W-1:0] tx_n = '0, ty_n = '0, nxp = '0, nxn = '0, nyp = '0, nyn = '0;
  bit q_exp [$];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every response pulse must match the oldest accepted op
  always @(negedge clk)
    if (!rst && (op_done || op_err)) begin
      if (q_exp.size() == 0) chk("resp_unexpected", {op_done, op_err}, 2'b00);
      else chk("resp_kind", {op_done, op_err}, q_exp.pop_front() ? 2'b10 : 2'b01);
      if (op_done) dones++;
    end

  task automatic put(int d, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] e);
    mxp[d] = a; mxn[d] = b; myp[d] = c; myn[d] = e;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) put(i, '0, '0, '0, '0);
    for (int i = 0; i < BEATS; i++) words[i] = '0;
    beat = 0; mqv = 0; busy = 0; pend_q = 0;
    q_exp.delete();
  endtask

  // one clock: drive at negedge, check handshake/q_valid against the model, advance the model
  task automatic cyc(bit ov, logic [2:0] c, int d, int s, bit cd, bit lv, logic [BW-1:0] ld);
    bit oacc, lacc, e;
    logic [W-1:0] qx, qy, sxp, sxn, syp, syn;
    op_vld = ov; op_code = c; op_dst = SW'(d); op_src = SW'(s); op_cond = cd;
    ld_vld = lv; ld_data = ld;
    t_x = tx_n; t_y = ty_n; fb_xp = nxp; fb_xn = nxn; fb_yp = nyp; fb_yn = nyn;
    #1;
    chk("op_rdy", op_rdy, !busy);
    chk("ld_rdy", ld_rdy, !pend_q);
    chk("q_valid", q_valid, mqv);
    oacc = ov && !busy;
    lacc = lv && !pend_q;
    e = c == OP_RSVD || d >= NS || s >= NS || (c == OP_SET_Q && !mqv);
    if (lacc) begin
      words[beat] = ld;
      if (beat == 0) mqv = 0;
      if (beat == BEATS - 1) mqv = 1;
      beat = (beat + 1) % BEATS;
    end
    if (oacc) begin
      q_exp.push_back(!e);
      if (!e) begin
        for (int k = 0; k < BEATS / 2; k++) begin
          qx[k*BW +: BW] = words[k];
          qy[k*BW +: BW] = words[k + BEATS / 2];
        end
        case (c)
          OP_SET_Q: put(d, qx, '0, qy, '0);
          OP_SET_T: put(d, tx_n, '0, ty_n, '0);
          OP_SET_N: put(d, nxp, nxn, nyp, nyn);
          OP_SET_M: put(d, P1_MXP, P1_MXN, P1_MYP, P1_MYN);
          OP_CLR:   put(d, '0, '0, '0, '0);
          OP_COPY:  put(d, mxp[s], mxn[s], myp[s], myn[s]);
          default: if (cd) begin
            sxp = mxp[d]; sxn = mxn[d]; syp = myp[d]; syn = myn[d];
            put(d, mxp[s], mxn[s], myp[s], myn[s]);
            put(s, sxp, sxn, syp, syn);
          end
        endcase
      end
    end
    busy = oacc;
    pend_q = oacc && c == OP_SET_Q && !e;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, OP_CLR, 0, 0, 0, 0, '0);
  endtask

  task automatic op1(logic [2:0] c, int d, int s, bit cd);
    cyc(1, c, d, s, cd, 0, '0);
    idle(1);
  endtask

  task automatic sweep();
    idle(1);
    for (int s = 0; s < NS; s++) begin
      rd_slot = SW'(s);
      #1;
      chk("slot_xp", rd_xp, mxp[s]);
      chk("slot_xn", rd_xn, mxn[s]);
      chk("slot_yp", rd_yp, myp[s]);
      chk("slot_yn", rd_yn, myn[s]);
    end
    @(negedge clk);
    busy = 0; pend_q = 0;
  endtask

  // asynchronous reset in the middle of a low phase, checked while still asserted
  task automatic do_reset();
    #2 rst = 1;
    model_clear();
    #1;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_ld_rdy", ld_rdy, 1);
    chk("rst_op_rdy", op_rdy, 1);
    for (int s = 0; s < NS; s++) begin
      rd_slot = SW'(s);
      #1;
      chk("rst_xp", rd_xp, '0);
      chk("rst_yp", rd_yp, '0);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic load(int n, int base);
    for (int i = 0; i < n; i++) cyc(0, OP_CLR, 0, 0, 0, 1, BW'(base + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_clear();
    @(negedge clk);
    do_reset();
    // mid-stream reset discards the partial load
    load(5, 100);
    cyc(1, OP_SET_M, 3, 0, 0, 1, 32'h55);
    do_reset();
    // 16 beats 1..16, then Q into slot 2
    load(16, 1);
    op1(OP_SET_Q, 2, 0, 0);
    sweep();
    rd_slot = 3'd2;
    #1;
    chk("q_slot2_xp", rd_xp, {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
    chk("q_slot2_yp", rd_yp, {32'h10, 32'hf, 32'he, 32'hd, 32'hc, 32'hb, 32'ha, 32'h9});
    // rejected ops leave slots untouched
    do_reset();
    op1(OP_SET_M, 1, 0, 0);
    op1(OP_SET_Q, 1, 0, 0);
    op1(OP_RSVD, 1, 0, 0);
    op1(OP_CLR, 5, 0, 0);
    op1(OP_COPY, 0, 6, 0);
    sweep();
    // M / T then conditional swaps, both conditions
    tx_n = 256'hA; ty_n = 256'hB;
    op1(OP_SET_M, 0, 0, 0);
    op1(OP_SET_T, 1, 0, 0);
    op1(OP_CSWAP, 0, 1, 1);
    sweep();
    op1(OP_CSWAP, 0, 1, 0);
    op1(OP_CSWAP, 2, 2, 1);
    op1(OP_COPY, 3, 3, 0);
    sweep();
    // op_vld held four cycles: two accepts
    d0 = dones;
    for (int i = 0; i < 4; i++) cyc(1, OP_COPY, 4, 0, 0, 0, '0);
    idle(2);
    chk("b2b_dones", 32'(dones - d0), 2);
    sweep();
    // SET_Q on the final beat sees old q_valid, then a valid SET_Q stalls the loader
    do_reset();
    load(15, 32'h200);
    cyc(1, OP_SET_Q, 1, 0, 0, 1, 32'h20f);
    idle(1);
    cyc(1, OP_SET_Q, 3, 0, 0, 1, 32'h300);
    cyc(0, OP_CLR, 0, 0, 0, 1, 32'h301);
    cyc(0, OP_CLR, 0, 0, 0, 1, 32'h301);
    sweep();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      tx_n = {8{$urandom}}; ty_n = {8{$urandom}};
      nxp = {8{$urandom}}; nxn = {8{$urandom}}; nyp = {8{$urandom}}; nyn = {8{$urandom}};
      cyc($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 5),
          $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if (i % 50 == 49) sweep();
    end
    sweep();
    idle(2);
    chk("sb_empty", 32'(q_exp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
